// File: rtl/sap_pkg.sv
// Shared definitions for the SAP datapath: serial adder FSM states and
// the default data width.
package sap_pkg;

  localparam int SAP_WIDTH = 32'sd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } sap_state_t;

endpackage : sap_pkg

// File: rtl/fa.sv
// Gate-level full adder: the single bit cell of the serial adder.
module fa (
  input  logic A,
  input  logic B,
  input  logic CIN,
  output logic SUM,
  output logic COUT
);

  logic axb_s;

  assign axb_s = A ^ B;
  assign SUM   = axb_s ^ CIN;
  assign COUT  = (A & B) | (CIN & axb_s);

endmodule : fa

// File: rtl/serial_adder.sv
// Bit-serial adder/subtracter, one bit per clock, LSB first.
// Subtraction is A + ~B + 1: B is inverted on load and the carry is
// seeded with 1. The result, carry and signed overflow are registered
// on the completion edge and held until the next completion or CLR.
module serial_adder
  import sap_pkg::*;
#(
  parameter int WIDTH = SAP_WIDTH
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             START,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             CARRY,
  output logic             OVF
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  sap_state_t       state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-2:0] res_sh_r;   // upper W-1 bits of the partial result
  logic             cy_r;
  logic             msb_a_r;
  logic             msb_b_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             ovf_r;

  logic             sum_bit_s;
  logic             cout_s;
  logic             start_ok_s;
  logic             last_bit_s;
  logic [WIDTH-1:0] res_next_s;
  logic [WIDTH-1:0] b_load_s;

  // The one full-adder cell shared by every bit position.
  fa u_fa (
    .A    (a_sh_r[0]),
    .B    (b_sh_r[0]),
    .CIN  (cy_r),
    .SUM  (sum_bit_s),
    .COUT (cout_s)
  );

  // Handshake qualifiers and the next partial result.
  always_comb begin
    start_ok_s = 1'b0;
    b_load_s   = B;
    if (START && ((state_r == ST_IDLE) || (state_r == ST_DONE))) begin
      start_ok_s = 1'b1;
    end else begin
      start_ok_s = 1'b0;
    end
    if (SUB) begin
      b_load_s = ~B;
    end else begin
      b_load_s = B;
    end
    last_bit_s = (cnt_r == CNT_LAST);
    res_next_s = {sum_bit_s, res_sh_r};
  end

  // FSM, operand/result shift registers, bit counter and result registers.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_r  <= ST_IDLE;
      a_sh_r   <= '0;
      b_sh_r   <= '0;
      res_sh_r <= '0;
      cy_r     <= 1'b0;
      msb_a_r  <= 1'b0;
      msb_b_r  <= 1'b0;
      cnt_r    <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      sum_r    <= '0;
      carry_r  <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start_ok_s) begin
            a_sh_r   <= A;
            b_sh_r   <= b_load_s;
            cy_r     <= SUB;
            msb_a_r  <= A[WIDTH-1];
            msb_b_r  <= b_load_s[WIDTH-1];
            cnt_r    <= '0;
            res_sh_r <= '0;
            state_r  <= ST_SHIFT;
            busy_r   <= 1'b1;
            done_r   <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
          res_sh_r <= res_next_s[WIDTH-1:1];
          cy_r     <= cout_s;
          cnt_r    <= cnt_r + CNT_ONE;
          if (last_bit_s) begin
            sum_r   <= res_next_s;
            carry_r <= cout_s;
            ovf_r   <= (msb_a_r == msb_b_r) && (sum_bit_s != msb_a_r);
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_SHIFT;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY  = busy_r;
  assign DONE  = done_r;
  assign SUM   = sum_r;
  assign CARRY = carry_r;
  assign OVF   = ovf_r;

endmodule : serial_adder

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial adder/subtracter for the SAP datapath. It is built around one full-adder cell and a carry flip-flop, and processes one bit per clock, LSB first. It consumes the full-adder stage's SUM/COUT each cycle and produces a registered WIDTH-bit result, carry and overflow for the accumulator / W-bus. Start/done handshake with the controller-sequencer.

Parameters:
WIDTH, 8, operand and result width in bits (≥2)

Ports:
CLK  input  1  system clock; all state changes on rising edge
CLR  input  1  reset, synchronous, active-high
START  input  1  request; sampled only when ready (state IDLE or DONE)
SUB  input  1  0 = A+B, 1 = A−B (two's complement); sampled with START
A  input  WIDTH  operand A (accumulator side); sampled with START
B  input  WIDTH  operand B (B-register side); sampled with START
BUSY  output  1  high while bits are being processed
DONE  output  1  one-cycle pulse; result outputs valid from this cycle onward
SUM  output  WIDTH  registered result; holds last result until next completion
CARRY  output  1  registered carry-out of MSB (for SUB: 1 = no borrow)
OVF  output  1  registered signed overflow

Behaviour:
- Interface: one clock, CLK; reset CLR is synchronous and active-high.
- Reset: on any edge with CLR=1:
  - state IDLE; all internal registers cleared
  - BUSY=0, DONE=0, SUM=0, CARRY=0, OVF=0
  - CLR has priority over everything, including mid-operation; a partial result is discarded, and SUM is not updated from it.
- States: IDLE, SHIFT, DONE (enum in package).
- IDLE, START=1 at an edge:
  - load a_sh←A, b_sh←(SUB ? ~B : B), cy←SUB, msb_a←A[W−1], msb_b←the loaded b_sh[W−1]
  - bit counter←0; go to SHIFT
- SHIFT, each edge:
  - full adder computes s,co from a_sh[0], b_sh[0], cy
  - a_sh, b_sh shift right by one; r_sh←{s, r_sh[W−1:1]}; cy←co; counter++
  - on the edge where counter==W−1 (the W-th bit): SUM←{s, r_sh[W−1:1]}, CARRY←co, OVF←(msb_a==msb_b)&&(s!=msb_a); go to DONE
- BUSY=1 exactly in SHIFT: W cycles.
- DONE: DONE=1 for exactly one cycle.
  - Without START: go to IDLE next edge.
  - With START=1: accept new operands exactly as in IDLE, go to SHIFT. Back-to-back operation, no idle gap.
- START while in SHIFT is ignored; it is not queued. SUB/A/B changes during SHIFT have no effect.
- Latency: START sampled at edge 0 → DONE high after edge W, i.e. W+1 cycles after the START cycle.
- SUM/CARRY/OVF change only on the completion edge or on CLR. During SHIFT they hold the previous result.
- Counter width: $clog2(WIDTH).
- Arithmetic: result is modulo 2^W; no saturation.

Decomposition:
- Shared package sap_pkg:
  - state typedef (IDLE/SHIFT/DONE)
  - default data width constant SAP_WIDTH=8
- One sub-module: the gate-level full adder fa (inputs A, B, CIN; outputs SUM, COUT), instantiated once for the bit cell.
- Shift registers, counter and FSM are inline.

Test Plan:
(WIDTH=8)
1. CLR for 2 cycles, then release → BUSY=0, DONE=0, SUM=0x00, CARRY=0, OVF=0. START pulse with A=0x05, B=0x03, SUB=0 → BUSY high 8 cycles, DONE pulse 9 cycles after START, SUM=0x08, CARRY=0, OVF=0.
2. Add boundary cases:
   - A=0xFF, B=0x01 → SUM=0x00, CARRY=1, OVF=0
   - A=0x7F, B=0x01 → SUM=0x80, CARRY=0, OVF=1
3. Subtract cases:
   - SUB=1, A=0x05, B=0x03 → SUM=0x02, CARRY=1, OVF=0
   - A=0x03, B=0x05 → SUM=0xFE, CARRY=0, OVF=0
   - A=0x80, B=0x01 → SUM=0x7F, CARRY=1, OVF=1
4. START in the DONE cycle with A=0x10, B=0x20 → no idle cycle, BUSY re-asserts next cycle, SUM=0x30. Earlier SUM holds throughout SHIFT.
5. START during SHIFT with different operands → ignored; first result unchanged, exactly one DONE pulse. Toggle A/B mid-SHIFT → result unaffected.
6. Previous SUM=0x08; start 0xFF+0x01; assert CLR on the 4th SHIFT cycle → next edge: BUSY=0, SUM=0x00, no DONE pulse. A fresh START afterwards computes correctly.
